fir_coeff_bank_ctrl: RTL and testbench
======================================

Name: fir_coeff_bank_ctrl

Overview:
Double-buffered coefficient controller for the single-channel FIR.
- Accepts a new coefficient set as a valid/ready word stream and writes it into the shadow bank.
- Swaps shadow and active banks only on a sample boundary, after software commits.
- Drives the active bank as a flat coefficient bus, so the MAC chain never sees a half-written filter.

Parameters:
C_W, 16, coefficient width (Q0.15 signed)
C_NUM, 33, number of taps / words per set
IDX_W, $clog2(C_NUM), write index width

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
cfg_valid  input  1  coefficient word valid
cfg_ready  output  1  controller can accept a word
cfg_data  input  C_W  coefficient word; tap 0 first
cfg_last  input  1  marks final word of a set
commit_req  input  1  one-cycle request to activate the loaded set
sample_strobe  input  1  one-cycle pulse at each FIR input sample boundary
coeff_flat  output  C_NUM*C_W  active bank; tap i at bits [i*C_W +: C_W]
bank_sel  output  1  index of the active bank
armed  output  1  shadow holds a complete, valid set
swap_done  output  1  one-cycle pulse when a swap takes effect
err_len  output  1  one-cycle pulse on a malformed set length

Behaviour:
- Storage: two banks of C_NUM x C_W registers. coeff_flat is registered from bank[bank_sel].
- Reset (synchronous, reset=1 at a clock edge) values:
  - both banks all zero, coeff_flat = 0, bank_sel = 0
  - armed = 0, swap_done = 0, err_len = 0, cfg_ready = 0
  - commit_pend = 0, write index = 0, FSM = IDLE
  - Reset mid-load or mid-drain discards the partial set.
- Handshake: a word transfers when cfg_valid && cfg_ready at a clock edge. cfg_data and cfg_last are sampled only on transfer.
- FSM states IDLE, LOAD, ARMED, DRAIN:
  - IDLE: cfg_ready = 1.
    - Transfer writes shadow[0], index := 1, go to LOAD.
    - If that transfer has cfg_last = 1 and C_NUM > 1: err_len pulse, stay in IDLE.
  - LOAD: cfg_ready = 1. Each transfer writes shadow[index], index++.
    - cfg_last on word C_NUM-1: go to ARMED, armed = 1 next cycle.
    - cfg_last before word C_NUM-1: err_len pulse, go to IDLE; the shadow contents are don't-care.
    - Word C_NUM-1 without cfg_last: err_len pulse, go to DRAIN.
  - DRAIN: cfg_ready = 1. Words are discarded until a transfer with cfg_last, then go to IDLE. No error pulse on exit.
  - ARMED: cfg_ready = 0. On sample_strobe && (commit_pend || commit_req):
    - bank_sel toggles, commit_pend cleared, armed cleared, go to IDLE.
    - coeff_flat reflects the new bank exactly 1 cycle after that edge; swap_done pulses in the same cycle coeff_flat changes.
- commit_pend:
  - Set by commit_req in LOAD or ARMED.
  - Ignored in IDLE and DRAIN (no effect).
  - Cleared on swap, on any err_len, and on reset.
  - commit_req coincident with sample_strobe in ARMED swaps the same cycle.
- The active bank is never written. The shadow is bank[~bank_sel]. Loading while a previous set is armed is impossible because cfg_ready = 0 in ARMED.
- sample_strobe with no pending commit: no effect.
- No arithmetic. The index counter saturates logically at C_NUM-1 and never wraps into the active bank.

Decomposition:
- Package fir_pkg:
  - C_W, C_NUM defaults
  - typedef coeff_t (logic signed [C_W-1:0])
  - enum cbc_state_t {IDLE, LOAD, ARMED, DRAIN}
- One natural sub-module: fir_coeff_bank, the two-bank register file with write port (bank, idx, data, we) and a registered flat read of the selected bank.
- FSM and handshake stay in the top.

Test Plan:
- Post-reset, load words 16'h0001..16'h0021 (33 words, last on the 33rd), pulse commit_req, then sample_strobe 5 cycles later -> armed = 1 after load; 1 cycle after the strobe edge bank_sel = 1, coeff_flat tap0 = 16'h0001, tap32 = 16'h0021, swap_done pulses once.
- Load with random cfg_valid gaps and commit_req issued mid-LOAD; strobe arrives before the load finishes -> no swap until ARMED; first strobe after ARMED swaps; all 33 taps match.
- Short set: cfg_last on word 10, then commit_req and sample_strobe -> err_len pulses once; bank_sel unchanged; coeff_flat unchanged.
- Long set: 36 words with cfg_last on the 36th -> err_len pulses at word 33; words 34-36 are accepted and discarded; FSM returns to IDLE; a following good set then swaps normally.
- In ARMED, sample_strobe without commit for 10 cycles -> cfg_ready = 0 and no swap; then commit_req coincident with sample_strobe -> swap in that cycle.
- Reset asserted after 20 words of a load -> all outputs return to reset values; coeff_flat = 0; a new full load and commit then yields bank_sel = 1.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR coefficient bank controller.
package fir_pkg;

  localparam int C_W_DEFAULT   = 16;
  localparam int C_NUM_DEFAULT = 33;

  typedef logic signed [C_W_DEFAULT-1:0] coeff_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ARMED,
    DRAIN
  } cbc_state_t;

  // A one-tap filter still needs a 1-bit index signal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Two-bank coefficient register file: one write port into either bank and a
// registered flat read of the selected bank.
module fir_coeff_bank #(
  parameter int C_W   = 16,
  parameter int C_NUM = 33,
  parameter int IDX_W = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               we,
  input  logic               wr_bank,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [C_W-1:0]     wr_data,
  input  logic               rd_bank,
  output logic [C_NUM*C_W-1:0] coeff_flat
);

  logic [C_W-1:0]       bank_q [2][C_NUM];
  logic [C_W-1:0]       bank_d [2][C_NUM];
  logic [C_NUM*C_W-1:0] flat_q;
  logic [C_NUM*C_W-1:0] flat_d;

  always_comb begin
    bank_d = bank_q;
    if (we && (int'(wr_idx) < C_NUM)) begin
      bank_d[wr_bank][wr_idx] = wr_data;
    end
  end

  for (genvar gi = 0; gi < C_NUM; gi++) begin : g_flat
    assign flat_d[gi*C_W +: C_W] = bank_q[rd_bank][gi];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bank_q <= '{default: '0};
      flat_q <= '0;
    end else begin
      bank_q <= bank_d;
      flat_q <= flat_d;
    end
  end

  assign coeff_flat = flat_q;

endmodule

// File: rtl/fir_coeff_bank_ctrl.sv
// Double-buffered FIR coefficient controller: streams a set into the shadow
// bank and swaps it in on a sample boundary once software commits.
module fir_coeff_bank_ctrl
  import fir_pkg::*;
#(
  parameter int C_W   = C_W_DEFAULT,
  parameter int C_NUM = C_NUM_DEFAULT,
  parameter int IDX_W = idx_width(C_NUM)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [C_W-1:0]       cfg_data,
  input  logic                 cfg_last,
  input  logic                 commit_req,
  input  logic                 sample_strobe,
  output logic [C_NUM*C_W-1:0] coeff_flat,
  output logic                 bank_sel,
  output logic                 armed,
  output logic                 swap_done,
  output logic                 err_len
);

  cbc_state_t       state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             bank_sel_q, bank_sel_d;
  logic             commit_pend_q, commit_pend_d;
  logic             armed_q, armed_d;
  logic             err_len_q, err_len_d;
  logic             swap_stage_q, swap_stage_d;
  logic             swap_done_q, swap_done_d;
  logic             cfg_ready_q, cfg_ready_d;

  logic             xfer;
  logic             wr_en;
  logic [IDX_W-1:0] cur_idx;
  logic             at_final;

  assign xfer     = cfg_valid && cfg_ready_q;
  // IDLE always writes tap 0, so the first word shares the LOAD datapath.
  assign cur_idx  = (state_q == LOAD) ? index_q : '0;
  assign at_final = (cur_idx == IDX_W'(C_NUM - 1));

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    bank_sel_d    = bank_sel_q;
    commit_pend_d = commit_pend_q;
    armed_d       = armed_q;
    err_len_d     = 1'b0;
    swap_stage_d  = 1'b0;
    wr_en         = 1'b0;

    case (state_q)
      IDLE, LOAD: begin
        if ((state_q == LOAD) && commit_req) commit_pend_d = 1'b1;
        if (xfer) begin
          wr_en   = 1'b1;
          index_d = '0;
          if (at_final && cfg_last) begin
            state_d = ARMED;
            armed_d = 1'b1;
          end else if (at_final) begin
            state_d   = DRAIN;
            err_len_d = 1'b1;
          end else if (cfg_last) begin
            state_d   = IDLE;
            err_len_d = 1'b1;
          end else begin
            state_d = LOAD;
            index_d = cur_idx + 1'b1;
          end
        end
      end
      ARMED: begin
        if (commit_req) commit_pend_d = 1'b1;
        if (sample_strobe && (commit_pend_q || commit_req)) begin
          bank_sel_d    = ~bank_sel_q;
          commit_pend_d = 1'b0;
          armed_d       = 1'b0;
          swap_stage_d  = 1'b1;
          state_d       = IDLE;
        end
      end
      DRAIN: begin
        if (xfer && cfg_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (err_len_d) commit_pend_d = 1'b0;
    cfg_ready_d = (state_d != ARMED);
    // coeff_flat picks up the new bank one edge after bank_sel, so delay the pulse to match.
    swap_done_d = swap_stage_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      index_q       <= '0;
      bank_sel_q    <= 1'b0;
      commit_pend_q <= 1'b0;
      armed_q       <= 1'b0;
      err_len_q     <= 1'b0;
      swap_stage_q  <= 1'b0;
      swap_done_q   <= 1'b0;
      cfg_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      bank_sel_q    <= bank_sel_d;
      commit_pend_q <= commit_pend_d;
      armed_q       <= armed_d;
      err_len_q     <= err_len_d;
      swap_stage_q  <= swap_stage_d;
      swap_done_q   <= swap_done_d;
      cfg_ready_q   <= cfg_ready_d;
    end
  end

  fir_coeff_bank #(
    .C_W   (C_W),
    .C_NUM (C_NUM),
    .IDX_W (IDX_W)
  ) u_bank (
    .clock      (clock),
    .reset      (reset),
    .we         (wr_en),
    .wr_bank    (~bank_sel_q),
    .wr_idx     (cur_idx),
    .wr_data    (cfg_data),
    .rd_bank    (bank_sel_q),
    .coeff_flat (coeff_flat)
  );

  assign cfg_ready = cfg_ready_q;
  assign bank_sel  = bank_sel_q;
  assign armed     = armed_q;
  assign swap_done = swap_done_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_fir_coeff_bank_ctrl.sv
// Self-checking bench for fir_coeff_bank_ctrl against a set-level model of the active filter.
module tb_fir_coeff_bank_ctrl;
  import fir_pkg::*;

  localparam int N = 33;
  localparam int W = 16;

  logic           clock = 1'b0;
  logic           reset;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [W-1:0]   cfg_data;
  logic           cfg_last;
  logic           commit_req;
  logic           sample_strobe;
  logic [N*W-1:0] coeff_flat;
  logic           bank_sel;
  logic           armed;
  logic           swap_done;
  logic           err_len;

  int checks_total  = 0;
  int checks_passed = 0;
  int err_pulses    = 0;
  int swap_pulses   = 0;

  coeff_t     words [64];
  logic [W-1:0] exp_active [N];
  logic         exp_sel;

  fir_coeff_bank_ctrl dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .commit_req(commit_req),
    .sample_strobe(sample_strobe), .coeff_flat(coeff_flat), .bank_sel(bank_sel),
    .armed(armed), .swap_done(swap_done), .err_len(err_len)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (err_len === 1'b1) err_pulses++;
    if (swap_done === 1'b1) swap_pulses++;
  end

  function automatic logic [N*W-1:0] model_flat();
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = exp_active[i];
    return v;
  endfunction

  // A committed, complete set becomes the active filter and the bank index flips.
  task automatic model_swap();
    for (int i = 0; i < N; i++) exp_active[i] = words[i];
    exp_sel = ~exp_sel;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) exp_active[i] = '0;
    exp_sel = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic randomize_words(input int n);
    for (int i = 0; i < n; i++) words[i] = coeff_t'($urandom_range(16'hFFFF, 0));
  endtask

  task automatic drive_word(input logic [W-1:0] d, input bit last, input int gap_max);
    int waited;
    repeat ($urandom_range(gap_max, 0)) tick();
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = last;
    waited    = 0;
    while (!cfg_ready && waited < 100) begin
      tick();
      waited++;
    end
    if (!cfg_ready) begin
      checks_total++;
      $display("FAIL handshake_timeout cfg_ready got %b want 1", cfg_ready);
    end
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic load_words(input int n, input int gap_max);
    for (int i = 0; i < n; i++) drive_word(words[i], i == n - 1, gap_max);
  endtask

  task automatic pulse_commit();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
  endtask

  task automatic pulse_strobe(input bit with_commit);
    sample_strobe = 1'b1;
    commit_req    = with_commit;
    tick();
    sample_strobe = 1'b0;
    commit_req    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks_total++; if (coeff_flat !== '0) $display("FAIL reset_coeff got %h want 0", coeff_flat); else checks_passed++;
    checks_total++; if ({bank_sel, armed, swap_done, err_len, cfg_ready} !== 5'b0)
      $display("FAIL reset_ctrl got %b want 00000", {bank_sel, armed, swap_done, err_len, cfg_ready}); else checks_passed++;
    reset = 1'b0;
    tick();
    checks_total++; if (cfg_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cfg_ready); else checks_passed++;
    model_reset();
  endtask

  task automatic test_basic_load();
    int sw0;
    logic [N*W-1:0] old_flat;
    for (int i = 0; i < N; i++) words[i] = coeff_t'(i + 1);
    load_words(N, 0);
    checks_total++; if (armed !== 1'b1) $display("FAIL basic_armed got %b want 1", armed); else checks_passed++;
    checks_total++; if (cfg_ready !== 1'b0) $display("FAIL basic_ready got %b want 0", cfg_ready); else checks_passed++;
    pulse_commit();
    repeat (4) tick();
    sw0 = swap_pulses;
    old_flat = model_flat();
    pulse_strobe(1'b0);
    checks_total++; if (bank_sel !== ~exp_sel) $display("FAIL basic_sel_edge got %b want %b", bank_sel, ~exp_sel); else checks_passed++;
    checks_total++; if (coeff_flat !== old_flat) $display("FAIL basic_flat_early got %h want %h", coeff_flat, old_flat); else checks_passed++;
    checks_total++; if (swap_done !== 1'b0) $display("FAIL basic_done_early got %b want 0", swap_done); else checks_passed++;
    model_swap();
    tick();
    checks_total++; if (coeff_flat !== model_flat()) $display("FAIL basic_flat got %h want %h", coeff_flat, model_flat()); else checks_passed++;
    checks_total++; if (coeff_flat[W-1:0] !== 16'h0001 || coeff_flat[32*W +: W] !== 16'h0021)
      $display("FAIL basic_taps got %h/%h want 0001/0021", coeff_flat[W-1:0], coeff_flat[32*W +: W]); else checks_passed++;
    checks_total++; if (swap_done !== 1'b1 || armed !== 1'b0) $display("FAIL basic_done got %b%b want 10", swap_done, armed); else checks_passed++;
    tick();
    checks_total++; if (swap_pulses - sw0 !== 1) $display("FAIL basic_done_count got %0d want 1", swap_pulses - sw0); else checks_passed++;
    checks_total++; if (bank_sel !== 1'b1) $display("FAIL basic_sel got %b want 1", bank_sel); else checks_passed++;
  endtask

  task automatic test_commit_mid_load();
    randomize_words(N);
    for (int i = 0; i < N; i++) begin
      drive_word(words[i], i == N - 1, 3);
      if (i == 14) pulse_commit();
      if (i == 20) begin
        pulse_strobe(1'b0);
        repeat (2) tick();
        checks_total++; if (bank_sel !== exp_sel) $display("FAIL midload_noswap got %b want %b", bank_sel, exp_sel); else checks_passed++;
      end
    end
    repeat ($urandom_range(6, 3)) tick();
    checks_total++; if (armed !== 1'b1 || bank_sel !== exp_sel)
      $display("FAIL midload_armed got %b%b want 1%b", armed, bank_sel, exp_sel); else checks_passed++;
    pulse_strobe(1'b0);
    model_swap();
    checks_total++; if (bank_sel !== exp_sel) $display("FAIL midload_sel got %b want %b", bank_sel, exp_sel); else checks_passed++;
    tick();
    checks_total++; if (coeff_flat !== model_flat()) $display("FAIL midload_flat got %h want %h", coeff_flat, model_flat()); else checks_passed++;
    checks_total++; if (swap_done !== 1'b1) $display("FAIL midload_done got %b want 1", swap_done); else checks_passed++;
    tick();
  endtask

  task automatic test_short_set();
    int e0;
    e0 = err_pulses;
    randomize_words(10);
    load_words(10, 1);
    checks_total++; if (err_len !== 1'b1) $display("FAIL short_err got %b want 1", err_len); else checks_passed++;
    pulse_commit();
    repeat (2) tick();
    pulse_strobe(1'b0);
    repeat (3) tick();
    checks_total++; if (err_pulses - e0 !== 1) $display("FAIL short_err_count got %0d want 1", err_pulses - e0); else checks_passed++;
    checks_total++; if (bank_sel !== exp_sel || armed !== 1'b0)
      $display("FAIL short_ctrl got %b%b want %b0", bank_sel, armed, exp_sel); else checks_passed++;
    checks_total++; if (coeff_flat !== model_flat()) $display("FAIL short_flat got %h want %h", coeff_flat, model_flat()); else checks_passed++;
  endtask

  task automatic test_long_set();
    int e0;
    e0 = err_pulses;
    randomize_words(36);
    for (int i = 0; i < 36; i++) begin
      drive_word(words[i], i == 35, 1);
      if (i == 32) begin
        checks_total++; if (err_len !== 1'b1) $display("FAIL long_err_at33 got %b want 1", err_len); else checks_passed++;
      end
    end
    tick();
    checks_total++; if (err_pulses - e0 !== 1) $display("FAIL long_err_count got %0d want 1", err_pulses - e0); else checks_passed++;
    checks_total++; if (cfg_ready !== 1'b1 || armed !== 1'b0)
      $display("FAIL long_idle got %b%b want 10", cfg_ready, armed); else checks_passed++;
    randomize_words(N);
    load_words(N, 2);
    pulse_commit();
    tick();
    pulse_strobe(1'b0);
    model_swap();
    tick();
    checks_total++; if (bank_sel !== exp_sel) $display("FAIL long_follow_sel got %b want %b", bank_sel, exp_sel); else checks_passed++;
    checks_total++; if (coeff_flat !== model_flat()) $display("FAIL long_follow_flat got %h want %h", coeff_flat, model_flat()); else checks_passed++;
    tick();
  endtask

  task automatic test_hold_armed();
    int sw0;
    int bad;
    randomize_words(N);
    load_words(N, 0);
    sw0 = swap_pulses;
    bad = 0;
    cfg_valid     = 1'b1;
    cfg_data      = 16'hDEAD;
    cfg_last      = 1'b1;
    sample_strobe = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cfg_ready !== 1'b0 || bank_sel !== exp_sel) bad++;
    end
    checks_total++; if (bad !== 0) $display("FAIL hold_noswap got %0d bad cycles want 0", bad); else checks_passed++;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    pulse_strobe(1'b1);
    model_swap();
    checks_total++; if (bank_sel !== exp_sel) $display("FAIL hold_sel got %b want %b", bank_sel, exp_sel); else checks_passed++;
    tick();
    checks_total++; if (coeff_flat !== model_flat()) $display("FAIL hold_flat got %h want %h", coeff_flat, model_flat()); else checks_passed++;
    tick();
    checks_total++; if (swap_pulses - sw0 !== 1) $display("FAIL hold_done_count got %0d want 1", swap_pulses - sw0); else checks_passed++;
  endtask

  task automatic test_reset_mid_load();
    randomize_words(20);
    for (int i = 0; i < 20; i++) drive_word(words[i], 1'b0, 1);
    reset = 1'b1;
    tick();
    tick();
    model_reset();
    checks_total++; if (coeff_flat !== '0) $display("FAIL rst_mid_flat got %h want 0", coeff_flat); else checks_passed++;
    checks_total++; if ({bank_sel, armed, swap_done, err_len, cfg_ready} !== 5'b0)
      $display("FAIL rst_mid_ctrl got %b want 00000", {bank_sel, armed, swap_done, err_len, cfg_ready}); else checks_passed++;
    reset = 1'b0;
    tick();
    randomize_words(N);
    load_words(N, 1);
    pulse_commit();
    pulse_strobe(1'b0);
    model_swap();
    tick();
    checks_total++; if (bank_sel !== 1'b1) $display("FAIL rst_mid_sel got %b want 1", bank_sel); else checks_passed++;
    checks_total++; if (coeff_flat !== model_flat()) $display("FAIL rst_mid_coeff got %h want %h", coeff_flat, model_flat()); else checks_passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      bit mid;
      mid = 1'($urandom_range(1, 0));
      randomize_words(N);
      for (int i = 0; i < N; i++) begin
        drive_word(words[i], i == N - 1, 2);
        if (mid && i == 5) pulse_commit();
      end
      repeat ($urandom_range(3, 0)) tick();
      pulse_strobe(!mid);
      model_swap();
      tick();
      checks_total++; if (bank_sel !== exp_sel) $display("FAIL b2b_sel round %0d got %b want %b", r, bank_sel, exp_sel); else checks_passed++;
      checks_total++; if (coeff_flat !== model_flat()) $display("FAIL b2b_flat round %0d got %h want %h", r, coeff_flat, model_flat()); else checks_passed++;
    end
  endtask

  initial begin
    reset         = 1'b1;
    cfg_valid     = 1'b0;
    cfg_data      = '0;
    cfg_last      = 1'b0;
    commit_req    = 1'b0;
    sample_strobe = 1'b0;
    model_reset();
    test_reset();
    test_basic_load();
    test_commit_mid_load();
    test_short_set();
    test_long_set();
    test_hold_armed();
    test_reset_mid_load();
    test_back_to_back();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
